// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives instruction-memory requests, holds the fetched word for decode, tracks the PC.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky fetch_err and halts on a misaligned redirect target.
module inst_fetch (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [5:0]  opCode,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic        fetch_err
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD,
      DISCARD
   } fetchState_t;

   fetchState_t state;
   logic [31:0] targetPc;

`ifdef FETCH_ALIGN_CHECK_EN
   logic        redirectBad;

   assign targetPc    = redirect_pc;
   assign redirectBad = redirect && (redirect_pc[1:0] != 2'b00);
`else
   // Word-aligned fetch only: the low target bits are dropped rather than trapped.
   logic        unusedPcLsbs;

   assign targetPc     = {redirect_pc[31:2], 2'b00};
   assign unusedPcLsbs = ^redirect_pc[1:0];
`endif

   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;
   assign opCode    = inst[31:26];

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         pc         <= '0;
         inst       <= '0;
         inst_valid <= 1'b0;
         imem_req   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         fetch_err  <= 1'b0;
`endif
      end
`ifdef FETCH_ALIGN_CHECK_EN
      else if (fetch_err || redirectBad) begin
         fetch_err  <= 1'b1;
         state      <= IDLE;
         inst_valid <= 1'b0;
         imem_req   <= 1'b0;
      end
`endif
      else begin
         case (state)
            IDLE: begin
               if (redirect)
                  pc <= targetPc;
               state    <= REQ;
               imem_req <= 1'b1;
            end

            REQ: begin
               if (redirect) begin
                  // An ack in the same cycle belongs to the old PC; without one it is still owed.
                  pc       <= targetPc;
                  state    <= imem_ack ? REQ : DISCARD;
                  imem_req <= imem_ack;
               end else if (imem_ack) begin
                  inst       <= imem_rdata;
                  inst_valid <= 1'b1;
                  state      <= HOLD;
                  imem_req   <= 1'b0;
               end
            end

            HOLD: begin
               if (redirect || inst_ready) begin
                  pc         <= redirect ? targetPc : pc_plus4;
                  inst_valid <= 1'b0;
                  state      <= REQ;
                  imem_req   <= 1'b1;
               end
            end

            DISCARD: begin
               if (redirect)
                  pc <= targetPc;
               if (imem_ack) begin
                  state    <= REQ;
                  imem_req <= 1'b1;
               end
            end

            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
